// File: rtl/mux_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the round-robin
// mux controller.
package mux_ctrl_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_8x1_v.sv
// Eight-input one-bit multiplexer shared by all requesters.
module mux_8x1_v (
    input  logic [7:0] I,
    input  logic [2:0] S,
    output logic       Y
);

    assign Y = I[S];

endmodule

// File: rtl/rr_pick8.sv
// Rotating priority search: first set request at or after 'start',
// ascending with wrap from the top index back to 0.
module rr_pick8
    import mux_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    assign any = |req;

    always_comb begin
        // NOTE: default before the loop keeps every path assigned, so no latch.
        winner = start;
        // Walk from the farthest slot back to 'start'; the last hit is the nearest.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[start + SEL_W'(i)]) begin
                winner = start + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_8x1_arbiter.sv
// Round-robin owner of the shared 8:1 mux select; grants one requester
// at a time for up to HOLD cycles and registers the selected bit.
module mux_8x1_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             dout_valid_q;

    logic [SEL_W-1:0] sel_inc;
    logic             last_cycle;
    logic [SEL_W-1:0] start_d;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             mux_y;

    assign sel_inc    = sel_q + SEL_W'(1);
    assign last_cycle = (state_q == GRANT) && (!req[sel_q] || (cnt_q == CNT_LAST));
    // A finishing grant searches from the slot after it, so its owner ranks last.
    assign start_d    = last_cycle ? sel_inc : ptr_q;

    rr_pick8 u_pick (
        .req    (req),
        .start  (start_d),
        .winner (winner),
        .any    (any_req)
    );

    mux_8x1_v u_mux (
        .I (din),
        .S (sel_q),
        .Y (mux_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_valid_q <= 1'b0;
                    if (any_req) begin
                        state_q <= GRANT;
                        gnt_q   <= onehot(winner);
                        sel_q   <= winner;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    dout_q       <= mux_y;
                    dout_valid_q <= 1'b1;
                    if (last_cycle) begin
                        ptr_q <= sel_inc;
                        cnt_q <= '0;
                        if (any_req) begin
                            gnt_q <= onehot(winner);
                            sel_q <= winner;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = |gnt_q;

endmodule

// File: tb/tb_mux_8x1_arbiter.sv
// Scoreboard bench: directed scenarios push expected grants and samples,
// a negedge monitor pops and compares whatever the active DUT presents.
module tb_mux_8x1_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] din = '0;

    logic [7:0] gnt_w   [3];
    logic [2:0] sel_w   [3];
    logic       dout_w  [3];
    logic       valid_w [3];
    logic       busy_w  [3];

    int act = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic [3:0] cnt;
    } grant_t;

    grant_t gq[$];
    logic   dq[$];

    always #5 clk = ~clk;

    mux_8x1_arbiter #(.HOLD(4)) u_h4 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .dout(dout_w[0]),
        .dout_valid(valid_w[0]), .busy(busy_w[0])
    );
    mux_8x1_arbiter #(.HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .dout(dout_w[1]),
        .dout_valid(valid_w[1]), .busy(busy_w[1])
    );
    mux_8x1_arbiter #(.HOLD(8)) u_h8 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_w[2]), .sel(sel_w[2]), .dout(dout_w[2]),
        .dout_valid(valid_w[2]), .busy(busy_w[2])
    );

    logic [7:0] act_gnt;
    logic [2:0] act_sel;
    logic       act_dout;
    logic       act_valid;
    logic       act_busy;
    logic [3:0] act_cnt;
    logic [2:0] act_ptr;

    always_comb begin
        act_gnt   = gnt_w[act];
        act_sel   = sel_w[act];
        act_dout  = dout_w[act];
        act_valid = valid_w[act];
        act_busy  = busy_w[act];
        case (act)
            1:       begin act_cnt = u_h1.cnt_q; act_ptr = u_h1.ptr_q; end
            2:       begin act_cnt = u_h8.cnt_q; act_ptr = u_h8.ptr_q; end
            default: begin act_cnt = u_h4.cnt_q; act_ptr = u_h4.ptr_q; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_g(input logic [7:0] g, input logic [2:0] s, input logic [3:0] c);
        grant_t e;
        e.gnt = g;
        e.sel = s;
        e.cnt = c;
        gq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (gq.size() == 0 && dq.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(negedge clk);
        check({name, "_grants_left"}, 32'(gq.size()), 32'd0);
        check({name, "_samples_left"}, 32'(dq.size()), 32'd0);
        gq.delete();
        dq.delete();
    endtask

    // Monitor: every grant cycle and every valid sample must match the next queued item.
    always @(negedge clk) begin
        grant_t e;
        logic   d;
        if (act_busy) begin
            if (gq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_grant: got gnt=%0h expected no grant at %0t", act_gnt, $time);
            end else begin
                e = gq.pop_front();
                check("gnt", 32'(act_gnt), 32'(e.gnt));
                check("sel", 32'(act_sel), 32'(e.sel));
                check("cnt", 32'(act_cnt), 32'(e.cnt));
            end
        end
        if (act_valid) begin
            if (dq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_sample: got dout=%0b expected no sample at %0t", act_dout, $time);
            end else begin
                d = dq.pop_front();
                check("dout", 32'(act_dout), 32'(d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [2:0] rot_sel  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       rot_dout [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic dbit;

        // Reset held with all requests pending: outputs stay zero.
        act = 0;
        #1;
        rst = 1'b1;
        req = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_gnt",   32'(act_gnt),   32'd0);
            check("rst_sel",   32'(act_sel),   32'd0);
            check("rst_dout",  32'(act_dout),  32'd0);
            check("rst_valid", 32'(act_valid), 32'd0);
            check("rst_busy",  32'(act_busy),  32'd0);
        end
        push_g(8'h01, 3'd0, 4'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        drain("reset");

        // Sole requester 5 with HOLD=4: re-granted back-to-back, cnt 0..3.
        do_reset();
        act = 0;
        for (int k = 1; k <= 8; k++) begin
            push_g(8'h20, 3'd5, 4'((k - 1) % 4));
            dq.push_back(k[0]);
        end
        tick();
        req = 8'h20;
        din = 8'hDF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            dbit = k[0];
            din  = dbit ? 8'h20 : 8'hDF;
            if (k == 8) req = 8'h00;
        end
        drain("sole");

        // Full rotation with HOLD=1.
        do_reset();
        act = 1;
        for (int k = 0; k < 9; k++) begin
            push_g(8'h01 << rot_sel[k], rot_sel[k], 4'd0);
            dq.push_back(rot_dout[k]);
        end
        tick();
        req = 8'hFF;
        din = 8'b1010_0110;
        repeat (9) tick();
        req = 8'h00;
        drain("rotation");

        // Early release with HOLD=8: requester 2 drops in its 2nd grant cycle.
        do_reset();
        act = 2;
        push_g(8'h04, 3'd2, 4'd0);
        push_g(8'h04, 3'd2, 4'd1);
        push_g(8'h40, 3'd6, 4'd0);
        dq.push_back(1'b1);
        dq.push_back(1'b1);
        dq.push_back(1'b0);
        tick();
        req = 8'h44;
        din = 8'h04;
        tick();
        tick();
        req = 8'h40;
        tick();
        req = 8'h00;
        drain("early");

        // Pointer wrap with HOLD=1: 6, then 0, then 1.
        do_reset();
        act = 1;
        push_g(8'h40, 3'd6, 4'd0);
        push_g(8'h01, 3'd0, 4'd0);
        push_g(8'h02, 3'd1, 4'd0);
        dq.push_back(1'b1);
        dq.push_back(1'b0);
        dq.push_back(1'b1);
        tick();
        req = 8'h40;
        din = 8'b0100_0010;
        tick();
        req = 8'h03;
        tick();
        check("ptr_after_6", 32'(act_ptr), 32'd7);
        tick();
        check("ptr_after_0", 32'(act_ptr), 32'd1);
        req = 8'h00;
        drain("wrap");

        // Asynchronous reset in requester 3's 2nd grant cycle, then idle.
        do_reset();
        act = 0;
        push_g(8'h08, 3'd3, 4'd0);
        push_g(8'h08, 3'd3, 4'd1);
        dq.push_back(1'b1);
        tick();
        req = 8'h08;
        din = 8'h08;
        tick();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt",   32'(act_gnt),   32'd0);
        check("async_valid", 32'(act_valid), 32'd0);
        check("async_busy",  32'(act_busy),  32'd0);
        req = 8'h00;
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy",  32'(act_busy),  32'd0);
        check("idle_gnt",   32'(act_gnt),   32'd0);
        check("idle_dout",  32'(act_dout),  32'd0);
        check("idle_valid", 32'(act_valid), 32'd0);
        drain("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_8x1_arbiter.md
# mux_8x1_arbiter

Round-robin controller that shares the team's 8:1 one-bit multiplexer between eight requesters. Each requester raises a request line; the arbiter grants one requester at a time and drives the mux select for that requester. It registers the selected data bit with a valid strobe. The block sits between the requester bank and downstream single-bit consumers, and owns the only select path into the mux.

## Interface
- HOLD, default 4: maximum consecutive grant cycles per grant. Legal range is 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request per requester; bit i belongs to requester i.
- din  in  8  data bit per requester; feeds mux inputs I[7:0].
- gnt  out  8  one-hot grant, or all zero when idle.
- sel  out  3  mux select, equal to the index of the granted requester. It holds its last value when idle.
- dout  out  1  registered mux output.
- dout_valid  out  1  dout carries a sample taken in a grant cycle.
- busy  out  1  high in every grant cycle (busy equals |gnt).

## Operation
- **Reset values.**
  - State IDLE.
  - gnt=0, sel=0, dout=0, dout_valid=0, busy=0.
  - Round-robin pointer ptr=0, hold counter cnt=0.
- **States.** There are two states: IDLE and GRANT.
- **Arbitration.** Search req starting at ptr, ascending, wrapping 7→0; the first set bit wins. Arbitration is combinational and evaluated on the current req.
- **IDLE.**
  - If req != 0: next state is GRANT, gnt=onehot(winner), sel=winner, cnt=0.
  - Otherwise remain in IDLE with gnt=0.
- **GRANT.** Every cycle in this state is a grant cycle.
  - The cycle is the last grant cycle when req[sel]==0 or cnt==HOLD-1.
  - Not the last grant cycle: cnt increments, and gnt/sel are unchanged.
  - Last grant cycle:
    - ptr <= sel+1 (mod 8).
    - If req has any bit set, arbitrate immediately from sel+1 (mod 8), not from the stale ptr. Load the new gnt/sel with cnt=0 and stay in GRANT, so grants run back-to-back with no idle gap.
    - Otherwise go to IDLE with gnt=0.
- **Releasing requester.** The requester that just finished is eligible again in the next arbitration, but only after all other pending requesters in rotation order. A sole requester is therefore re-granted back-to-back.
- **Data path.**
  - The mux output is din[sel].
  - In every grant cycle, dout <= din[sel] and dout_valid <= 1.
  - In IDLE cycles, dout_valid <= 0 and dout holds its value.
- **Late request drop.** A grant cycle in which req[sel] has already dropped still produces a valid sample; dropping req releases the grant from the following cycle.
- **Simultaneous events.** New requests arriving during a grant never pre-empt it; they wait for its last cycle.
- **Reset mid-grant.** Asserting rst forces all reset values immediately and asynchronously. Any in-flight sample is discarded with dout_valid=0. After release, arbitration restarts from ptr=0.

## Timing
- **Grant latency.**
  - req is sampled at edge N with the block in IDLE.
  - gnt and sel are valid after edge N, and the first grant cycle is cycle N..N+1.
- **Data latency.** 1 cycle: the din[sel] sample of a grant cycle appears on dout, with dout_valid=1, after the next edge.
- **Grant length.** Each grant is min(HOLD, cycles until req[sel] is seen low, including that cycle) grant cycles.
- **Throughput.** 1 sample per cycle while any request is pending, with no bubbles between grants.
- **Counter width.** cnt is 4 bits and is compared against HOLD-1; it never wraps past HOLD-1.

## Structure
- **Shared package (mux_ctrl_pkg).**
  - Constants N_REQ=8 and SEL_W=3.
  - State enum {IDLE, GRANT}.
- **Sub-modules.**
  - A single instance of the team's existing 8:1 mux, mux_8x1_v, with I=din, S=sel, Y feeding the dout register.
  - The round-robin search is a natural sub-module, rr_pick8: inputs req[7:0] and start[2:0]; outputs winner[2:0] and any.

## Test plan
- **Reset.** Assert rst for 3 cycles with req=8'hFF, then deassert it mid-cycle. Required: all outputs 0 while reset is asserted; first gnt=8'h01 one edge after release.
- **Sole requester, hold limit.** HOLD=4, req=8'h20 held, din[5] toggling each cycle. Required:
  - gnt=8'h20 and sel=5 continuously, with no gap.
  - dout reproduces din[5] delayed one cycle; dout_valid stays 1.
  - Internal cnt cycles 0,1,2,3.
- **Full rotation.** HOLD=1, req=8'hFF, din=8'b10100110. Required:
  - sel sequence 0,1,2,3,4,5,6,7,0.
  - dout sequence 0,1,1,0,0,1,0,1, each one cycle after its sel.
- **Early release.** HOLD=8, req=8'h44.
  - Required: requester 2 is granted first.
  - Drop req[2] in its 2nd grant cycle. Required: requester 2 gets exactly 2 grant cycles; gnt=8'h40 on the next cycle.
- **Pointer wrap.** HOLD=1, req=8'h40 for one grant, then req=8'h03. Required:
  - ptr goes to 7 after the requester-6 grant.
  - Next grants are requester 0 then requester 1, so 7 wraps to 0.
- **Mid-grant reset and idle.**
  - During requester 3's 2nd grant cycle, assert rst asynchronously. Required: gnt=0 and dout_valid=0 at once, without waiting for a clock edge.
  - Release rst with req=8'h00. Required: busy=0, gnt=0, and dout holding at 0.
